// File: rtl/uart_pkg.sv
// Shared UART constants: data width default, oversampling ratio, stop ticks
// and a helper that computes the baud divisor for a clock/baud pair.
package uart_pkg;

    localparam int DEF_DBITS  = 8;
    localparam int SB_TICK    = 16;
    localparam int OVERSAMPLE = 16;

    // Divisor = clk_freq / (OVERSAMPLE * baud) - 1
    function automatic int calc_dvsr(input int clk_freq, input int baud);
        return clk_freq / (OVERSAMPLE * baud) - 1;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversampling tick generator: s_tick pulses once every dvsr+1 clocks while en=1.
// Ports: clk, reset (async high), en, dvsr -> s_tick (registered).
module baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              s_tick
);

    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            // >= so a divisor lowered below the count wraps immediately
            if (cnt_q >= dvsr) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DVSR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign s_tick = tick_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tick generation plus a show-ahead byte FIFO with
// valid/ready output, level/full status and sticky overrun.
// Ports: clk, reset, en, dvsr -> s_tick; rx_done_tick, rx_dout in;
// m_data, m_valid, m_ready; level, full, overrun, clr_overrun.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBITS  = DEF_DBITS,
    parameter int DVSR_W = 11,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [DBITS-1:0]  rx_dout,
    output logic [DBITS-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .dvsr   (dvsr),
        .s_tick (s_tick)
    );

    logic [DBITS-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overrun_q, overrun_d;
    logic              push, pop, drop;

    assign full    = (level_q == DEPTH_L);
    assign m_valid = (level_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign overrun = overrun_q;

    always_comb begin
        pop  = m_valid & m_ready;
        // A same-cycle pop frees the slot, so a full FIFO still accepts
        push = rx_done_tick & (~full | pop);
        drop = rx_done_tick & full & ~pop;

        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase

        // A new drop beats a coincident clear
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: contents are ignored while level is 0
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_dout;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: tick timing, FIFO order, wrap,
// full/overrun, simultaneous push/pop at full, and async reset mid-stream.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [10:0] dvsr = '0;
    logic        s_tick;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_dout = '0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [4:0]  level;
    logic        full;
    logic        overrun;
    logic        clr_overrun = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb_q[$];
    bit         exp_ovr = 1'b0;

    uart_rx_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .dvsr         (dvsr),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .full         (full),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status();
        chk("level", 32'(level), 32'(sb_q.size()));
        chk("m_valid", 32'(m_valid), 32'(sb_q.size() != 0));
        chk("full", 32'(full), 32'(sb_q.size() == 16));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        if (sb_q.size() != 0) chk("m_data_head", 32'(m_data), 32'(sb_q[0]));
    endtask

    // One clock of stimulus with the scoreboard model updated alongside
    task automatic cyc(input bit dv, input logic [7:0] d, input bit rdy,
                       input bit clr);
        bit pop_m, push_m, drop_m;
        rx_done_tick = dv;
        rx_dout      = d;
        m_ready      = rdy;
        clr_overrun  = clr;
        pop_m  = rdy && (sb_q.size() != 0);
        push_m = dv && ((sb_q.size() < 16) || pop_m);
        drop_m = dv && (sb_q.size() == 16) && !pop_m;
        if (pop_m) begin
            chk("pop_data", 32'(m_data), 32'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (push_m) sb_q.push_back(d);
        if (drop_m) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
        step();
        rx_done_tick = 1'b0;
        m_ready      = 1'b0;
        clr_overrun  = 1'b0;
        chk_status();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc(0, 8'h00, 1, 0);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_s_tick", 32'(s_tick), 32'd0);
        chk_status();

        // Tick every 4th clock with dvsr=3
        dvsr = 11'd3;
        en   = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("tick_run", 32'(s_tick), 32'(k % 4 == 0));
        end
        en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("tick_off", 32'(s_tick), 32'd0);
        end
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("tick_restart", 32'(s_tick), 32'(k % 4 == 0));
        end
        en = 1'b0;

        // Single byte
        cyc(1, 8'hA5, 0, 0);
        chk("single_data", 32'(m_data), 32'hA5);
        cyc(0, 8'h00, 1, 0);

        // Ordering and pointer wrap with small occupancy
        for (int i = 0; i < 32; i++) cyc(1, 8'(i), (i % 3) != 0, 0);
        drain();

        // Fill past full: 0x20 is dropped
        for (int i = 0; i < 17; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        chk("ovr_set", 32'(overrun), 32'd1);
        drain();
        cyc(0, 8'h00, 0, 1);
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(1, 8'h55, 1, 0);
        chk("simul_level", 32'(level), 32'd16);
        chk("simul_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
        chk("last_is_55", 32'(m_data), 32'h55);
        drain();

        // Async reset with 5 bytes buffered, overrun set and ticks running
        for (int i = 0; i < 17; i++) cyc(1, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1, 0);
        dvsr = 11'd0;
        en   = 1'b1;
        step();
        chk("pre_rst_tick", 32'(s_tick), 32'd1);
        chk("pre_rst_level", 32'(level), 32'd5);
        #3;
        reset = 1'b1;
        #1;
        sb_q.delete();
        exp_ovr = 1'b0;
        chk("rst_tick", 32'(s_tick), 32'd0);
        chk_status();
        @(posedge clk);
        #2;
        reset = 1'b0;
        en    = 1'b0;
        #2;
        cyc(1, 8'h3C, 0, 0);
        chk("post_rst_head", 32'(m_data), 32'h3C);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
